// File: rtl/dpi_client_tx_arbiter_if.sv
// Producer-side handshake bundle for dpi_client_tx_arbiter, plus the per-call
// send hook that stands in for the DPI socket call when the DPI is not linked.
interface dpi_client_tx_arbiter_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]        in_vld;
    logic [N_CH-1:0]        in_rdy;
    logic [N_CH*DATA_W-1:0] in_data;

    // send_vld_c is high in every cycle whose closing edge makes a send call
    logic                   send_vld_c;
    logic [CH_W-1:0]        send_ch_c;
    logic [63:0]            send_data_c;
    logic                   send_ok;

    modport master (
        output in_vld, in_data, send_ok,
        input  in_rdy, send_vld_c, send_ch_c, send_data_c
    );

    modport slave (
        input  in_vld, in_data, send_ok,
        output in_rdy, send_vld_c, send_ch_c, send_data_c
    );
endinterface

// File: rtl/dpi_client_tx_arbiter.sv
// Per-channel FIFOs feeding a round-robin arbiter that hands one word per call
// to the host socket server, retrying rejected words with optional spacing/limit.
module dpi_client_tx_arbiter #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RETRY_GAP  = 0,
    parameter int unsigned MAX_RETRY  = 0,
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    dpi_client_tx_arbiter_if.slave     bus,
    output logic                       idle,
    output logic                       drop_pulse,
    output logic [CH_W-1:0]            drop_ch,
    output logic [31:0]                sent_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t             state;
    logic [CH_W-1:0]    ch_q;
    logic [CH_W-1:0]    rr_ptr;
    logic [31:0]        retry_cnt;
    logic [31:0]        gap_cnt;
    logic               rdy_en;

    logic [DATA_W-1:0]  mem    [N_CH][FIFO_DEPTH];
    logic [CNT_W-1:0]   wr_ptr [N_CH];
    logic [CNT_W-1:0]   rd_ptr [N_CH];

    logic [N_CH-1:0]    empty_c;
    logic [N_CH-1:0]    full_c;
    logic [N_CH-1:0]    rdy_c;
    logic [N_CH-1:0]    push_c;
    logic               grant_vld_c;
    logic [CH_W-1:0]    grant_ch_c;
    logic [CH_W:0]      rr_sum_c;
    logic [CH_W-1:0]    next_ch_c;
    logic [DATA_W-1:0]  head_c;

    // FIFO status; pointers carry one extra wrap bit
    always_comb begin
        empty_c = '0;
        full_c  = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            empty_c[c] = (wr_ptr[c] == rd_ptr[c]);
            full_c[c]  = ((wr_ptr[c] - rd_ptr[c]) == CNT_W'(FIFO_DEPTH));
        end
    end

    assign rdy_c      = rdy_en ? ~full_c : '0;
    assign push_c     = bus.in_vld & rdy_c;
    assign bus.in_rdy = rdy_c;

    // Cyclic search for the first non-empty channel starting at rr_ptr
    always_comb begin
        grant_vld_c = 1'b0;
        grant_ch_c  = '0;
        rr_sum_c    = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            rr_sum_c = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (rr_sum_c >= (CH_W+1)'(N_CH))
                rr_sum_c = rr_sum_c - (CH_W+1)'(N_CH);
            if (!grant_vld_c && !empty_c[rr_sum_c[CH_W-1:0]]) begin
                grant_vld_c = 1'b1;
                grant_ch_c  = rr_sum_c[CH_W-1:0];
            end
        end
    end

    assign next_ch_c       = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
    assign head_c          = mem[ch_q][rd_ptr[ch_q][PTR_W-1:0]];
    assign bus.send_vld_c  = (state == S_SEND);
    assign bus.send_ch_c   = ch_q;
    assign bus.send_data_c = 64'(head_c);
    assign idle            = (state == S_IDLE) && (&empty_c);

    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(N_CH); c++)
            if (push_c[c]) mem[c][wr_ptr[c][PTR_W-1:0]] <= bus.in_data[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ch_q       <= '0;
            rr_ptr     <= '0;
            retry_cnt  <= '0;
            gap_cnt    <= '0;
            rdy_en     <= 1'b0;
            drop_pulse <= 1'b0;
            drop_ch    <= '0;
            sent_cnt   <= '0;
            for (int c = 0; c < int'(N_CH); c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            rdy_en     <= 1'b1;
            drop_pulse <= 1'b0;
            for (int c = 0; c < int'(N_CH); c++)
                if (push_c[c]) wr_ptr[c] <= wr_ptr[c] + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    if (grant_vld_c) begin
                        ch_q      <= grant_ch_c;
                        retry_cnt <= '0;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.send_ok) begin
                        rd_ptr[ch_q] <= rd_ptr[ch_q] + CNT_W'(1);
                        sent_cnt     <= sent_cnt + 32'd1;
                        rr_ptr       <= next_ch_c;
                        state        <= S_IDLE;
                    end else if ((MAX_RETRY != 0) && (retry_cnt + 32'd1 == 32'(MAX_RETRY))) begin
                        rd_ptr[ch_q] <= rd_ptr[ch_q] + CNT_W'(1);
                        drop_pulse   <= 1'b1;
                        drop_ch      <= ch_q;
                        rr_ptr       <= next_ch_c;
                        state        <= S_IDLE;
                    end else begin
                        retry_cnt <= retry_cnt + 32'd1;
                        if (RETRY_GAP != 0) begin
                            gap_cnt <= 32'(RETRY_GAP);
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    gap_cnt <= gap_cnt - 32'd1;
                    if (gap_cnt == 32'd1) state <= S_SEND;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpi_client_tx_arbiter.sv
// Directed bench: instance a (RETRY_GAP=2, retry forever) and instance b
// (MAX_RETRY=3, no gap), both answering send calls through the interface hook.
`timescale 1ns/1ps
module tb_dpi_client_tx_arbiter;
    localparam int unsigned N_CH   = 4;
    localparam int unsigned DATA_W = 64;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        idle_a, idle_b, drop_pulse_a, drop_pulse_b;
    logic [1:0]  drop_ch_a, drop_ch_b;
    logic [31:0] sent_cnt_a, sent_cnt_b;

    always #5 clk = ~clk;

    dpi_client_tx_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus_a ();
    dpi_client_tx_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus_b ();

    dpi_client_tx_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(4),
                            .RETRY_GAP(2), .MAX_RETRY(0)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a), .idle(idle_a),
        .drop_pulse(drop_pulse_a), .drop_ch(drop_ch_a), .sent_cnt(sent_cnt_a));

    dpi_client_tx_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(4),
                            .RETRY_GAP(0), .MAX_RETRY(3)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b), .idle(idle_b),
        .drop_pulse(drop_pulse_b), .drop_ch(drop_ch_b), .sent_cnt(sent_cnt_b));

    int          cyc = 0;
    int          n_a = 0, n_b = 0, base_a = 0, rej_a = 0;
    int          drops_a = 0, drops_b = 0;
    int          log_ch_a[$], log_cyc_a[$], log_ch_b[$], log_cyc_b[$];
    logic [63:0] log_data_a[$], log_data_b[$];
    int          n_checks = 0, n_errors = 0;
    int          p;

    always @(posedge clk) cyc <= cyc + 1;

    // Server model for a: reject the first rej_a calls since base_a (forever if negative)
    assign bus_a.send_ok = (rej_a >= 0) && ((n_a - base_a) > rej_a);
    assign bus_b.send_ok = (bus_b.send_data_c != 64'hA5);

    // A call seen here happens at the next rising edge
    always @(negedge clk) begin
        if (!rst_a && bus_a.send_vld_c) begin
            log_ch_a.push_back(int'(bus_a.send_ch_c));
            log_data_a.push_back(bus_a.send_data_c);
            log_cyc_a.push_back(cyc + 1);
            n_a = n_a + 1;
        end
        if (!rst_b && bus_b.send_vld_c) begin
            log_ch_b.push_back(int'(bus_b.send_ch_c));
            log_data_b.push_back(bus_b.send_data_c);
            log_cyc_b.push_back(cyc + 1);
            n_b = n_b + 1;
        end
        if (drop_pulse_a) drops_a = drops_a + 1;
        if (drop_pulse_b) drops_b = drops_b + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        bus_a.in_vld = '0;
        tick(2);
        @(negedge clk);
        rst_a = 1'b0;
        tick(1);
    endtask

    task automatic push_a(input int ch, input logic [63:0] d);
        @(negedge clk);
        bus_a.in_vld = 4'(1 << ch);
        bus_a.in_data[ch*64 +: 64] = d;
        @(posedge clk);
        #1;
        bus_a.in_vld = '0;
    endtask

    task automatic push_b(input int ch, input logic [63:0] d);
        @(negedge clk);
        bus_b.in_vld = 4'(1 << ch);
        bus_b.in_data[ch*64 +: 64] = d;
        @(posedge clk);
        #1;
        bus_b.in_vld = '0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.in_vld = '0; bus_a.in_data = '0;
        bus_b.in_vld = '0; bus_b.in_data = '0;
        tick(2);
        check("rst_in_rdy", 64'(bus_a.in_rdy), 64'h0);
        check("rst_idle", 64'(idle_a), 64'h1);
        check("rst_sent_cnt", 64'(sent_cnt_a), 64'h0);
        check("rst_drop_pulse", 64'(drop_pulse_a), 64'h0);
        check("rst_drop_ch", 64'(drop_ch_a), 64'h0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1 check("rdy_before_edge", 64'(bus_a.in_rdy), 64'h0);
        tick(1);
        check("rdy_after_release", 64'(bus_a.in_rdy), 64'hF);

        // Single word on channel 2
        base_a = n_a; rej_a = 0;
        push_a(2, 64'hDEAD_BEEF);
        p = cyc;
        check("single_idle_low", 64'(idle_a), 64'h0);
        tick(6);
        check("single_ncalls", 64'(n_a - base_a), 64'd1);
        check("single_ch", 64'(log_ch_a[base_a]), 64'd2);
        check("single_data", log_data_a[base_a], 64'h0000_0000_DEAD_BEEF);
        check("single_edge", 64'(log_cyc_a[base_a]), 64'(p + 2));
        check("single_sent", 64'(sent_cnt_a), 64'd1);
        check("single_idle_back", 64'(idle_a), 64'h1);

        // Fairness: 3 rounds of {ch, seq} on all channels
        reset_a();
        base_a = n_a; rej_a = 0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            bus_a.in_vld = 4'hF;
            for (int c = 0; c < 4; c++) bus_a.in_data[c*64 +: 64] = 64'((c << 8) | s);
            @(posedge clk);
            #1;
        end
        bus_a.in_vld = '0;
        tick(30);
        check("fair_ncalls", 64'(n_a - base_a), 64'd12);
        for (int k = 0; k < 12; k++) begin
            check("fair_ch", 64'(log_ch_a[base_a + k]), 64'(k % 4));
            check("fair_data", log_data_a[base_a + k], 64'(((k % 4) << 8) | (k / 4)));
        end
        check("fair_span", 64'(log_cyc_a[base_a + 11] - log_cyc_a[base_a]), 64'd22);
        check("fair_sent", 64'(sent_cnt_a), 64'd12);

        // Retry: three rejections spaced by two call-free cycles, then accept
        reset_a();
        base_a = n_a; rej_a = 3;
        push_a(0, 64'h55);
        p = cyc;
        tick(16);
        check("retry_ncalls", 64'(n_a - base_a), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check("retry_data", log_data_a[base_a + k], 64'h55);
            check("retry_edge", 64'(log_cyc_a[base_a + k]), 64'(p + 2 + 3*k));
        end
        check("retry_sent", 64'(sent_cnt_a), 64'd1);
        check("retry_no_drop", 64'(drops_a), 64'd0);

        // Backpressure: server rejects forever, channels 0 and 1 fill up
        reset_a();
        base_a = n_a; rej_a = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rdy_open", 64'(bus_a.in_rdy), 64'hF);
            bus_a.in_vld = 4'b0011;
            bus_a.in_data[0 +: 64]  = 64'(32'h100 + i);
            bus_a.in_data[64 +: 64] = 64'(32'h200 + i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_rdy_full", 64'(bus_a.in_rdy), 64'hC);
        bus_a.in_vld = 4'b0001;
        bus_a.in_data[0 +: 64] = 64'h104;
        tick(5);
        check("bp_rdy_held", 64'(bus_a.in_rdy), 64'hC);
        bus_a.in_vld = '0;
        check("bp_sent", 64'(sent_cnt_a), 64'd0);
        check("bp_calls_made", 64'(n_a - base_a > 2), 64'd1);
        check("bp_last_ch", 64'(log_ch_a[n_a - 1]), 64'd0);
        check("bp_last_data", log_data_a[n_a - 1], 64'h100);

        // Reset while channel 3's word is in SEND with a second word queued
        reset_a();
        base_a = n_a; rej_a = -1;
        push_a(3, 64'h301);
        push_a(3, 64'h302);
        #1 rst_a = 1'b1;
        #1;
        check("rstmid_idle", 64'(idle_a), 64'h1);
        check("rstmid_rdy", 64'(bus_a.in_rdy), 64'h0);
        check("rstmid_drop", 64'(drop_pulse_a), 64'h0);
        check("rstmid_send_vld", 64'(bus_a.send_vld_c), 64'h0);
        tick(3);
        check("rstmid_no_call_in_rst", 64'(n_a - base_a), 64'd0);
        @(negedge clk);
        rst_a = 1'b0; rej_a = 0;
        tick(10);
        check("rstmid_no_call_after", 64'(n_a - base_a), 64'd0);
        check("rstmid_idle_after", 64'(idle_a), 64'h1);
        check("rstmid_sent", 64'(sent_cnt_a), 64'd0);

        // Drop on instance b: channel 1's 0xA5 rejected three times
        push_b(1, 64'hA5);
        p = cyc;
        push_b(1, 64'h5A);
        tick(3);
        check("drop_pulse_hi", 64'(drop_pulse_b), 64'h1);
        check("drop_ch", 64'(drop_ch_b), 64'd1);
        check("drop_sent_same", 64'(sent_cnt_b), 64'd0);
        tick(1);
        check("drop_pulse_lo", 64'(drop_pulse_b), 64'h0);
        tick(4);
        check("drop_ncalls", 64'(n_b), 64'd4);
        for (int k = 0; k < 3; k++) begin
            check("drop_call_data", log_data_b[k], 64'hA5);
            check("drop_call_edge", 64'(log_cyc_b[k]), 64'(p + 2 + k));
        end
        check("drop_next_ch", 64'(log_ch_b[3]), 64'd1);
        check("drop_next_data", log_data_b[3], 64'h5A);
        check("drop_next_edge", 64'(log_cyc_b[3]), 64'(p + 6));
        check("drop_count", 64'(drops_b), 64'd1);
        check("drop_sent_after", 64'(sent_cnt_b), 64'd1);
        check("drop_ch_held", 64'(drop_ch_b), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dpi_client_tx_arbiter.md
# dpi_client_tx_arbiter

Multi-channel successor to the single-producer CPU DPI client. It accepts words from N_CH independent valid/ready producers and buffers each channel in its own FIFO. A round-robin arbiter forwards the words one at a time to the host socket server through a per-channel DPI send call, retrying any word the server rejects. Retry spacing and a retry limit are parametrised. The block is simulation-only and sits between the CPU models and the DPI socket layer.

## Interface
- N_CH, 4: number of producer channels (1..16).
- DATA_W, 64: payload width (1..64). Payload is zero-extended to 64 bits for the DPI call.
- FIFO_DEPTH, 4: entries per channel FIFO (power of 2, >= 2).
- RETRY_GAP, 0: idle cycles between a rejected call and its retry.
- MAX_RETRY, 0: consecutive rejections before a word is dropped (0 = retry forever).
- DPI import: dpi_cpu_client_send_data_ch(input int channel, input bit [63:0] data) returns int; bit0 = 1 means the server accepted the word.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-high.
- in_vld  in  N_CH  per-channel word valid.
- in_rdy  out  N_CH  per-channel FIFO not full.
- in_data  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- idle  out  1  FSM in IDLE and all FIFOs empty.
- drop_pulse  out  1  one-cycle pulse when a word is dropped.
- drop_ch  out  $clog2(N_CH) (min 1)  channel of the last dropped word.
- sent_cnt  out  32  count of accepted words; wraps at 2^32.

## Operation
- Push: channel c writes in_data[c] on a posedge when in_vld[c] && in_rdy[c].
  - in_rdy[c] = !full[c].
  - No pass-through: a full FIFO refuses a push even in a cycle where it pops.
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - If any FIFO is non-empty, grant the first non-empty channel at or after rr_ptr (cyclic search).
  - Latch the granted channel in ch_q, clear retry_cnt, go to SEND.
  - No DPI call is made in IDLE.
- SEND: exactly one DPI call per cycle, with (ch_q, zero-extended FIFO head of ch_q).
  - The head is never popped while a word is in flight, so every retry resends the identical word.
  - Accepted (bit0 = 1):
    - pop the head; sent_cnt++;
    - rr_ptr = (ch_q+1) mod N_CH;
    - go to IDLE.
  - Rejected, with MAX_RETRY != 0 and retry_cnt+1 == MAX_RETRY:
    - pop the head; drop_pulse = 1; drop_ch = ch_q;
    - rr_ptr = ch_q+1; go to IDLE.
  - Rejected, otherwise:
    - retry_cnt++.
    - If RETRY_GAP == 0, stay in SEND.
    - Else load gap_cnt = RETRY_GAP and go to WAIT.
- WAIT: decrement gap_cnt; when it reaches 1, go to SEND. This gives exactly RETRY_GAP call-free cycles.
- Pushes to any channel, including ch_q, continue in every state.
- Reset (asynchronous, any state):
  - FIFOs empty; state IDLE.
  - rr_ptr, retry_cnt and gap_cnt cleared.
  - A word in flight is discarded; no DPI call is made while rst is high.
- Reset values: in_rdy = 0 while rst is high, and all-ones from the first edge after release.
  - idle = 1, drop_pulse = 0, drop_ch = 0, sent_cnt = 0.

## Timing
- Push at edge k → grant at edge k+1 → first DPI call at edge k+2.
- Back-to-back words need 2 cycles each (IDLE + SEND), so peak throughput is 1 word per 2 cycles.
- The freed FIFO slot is visible on in_rdy in the cycle after the accepting or dropping edge.
- A rejected word is retried every RETRY_GAP+1 cycles.
- drop_pulse is high for the single cycle after the dropping edge.
- drop_ch holds its value until the next drop.
- idle deasserts combinationally in the cycle after a push lands.
- Fairness: with all channels continuously non-empty, grants cycle 0,1,..,N_CH-1,0.

## Test plan
- Single word: N_CH=4; channel 2 pushes 0xDEAD_BEEF and the server always accepts.
  - Exactly one call (2, 0x00000000DEADBEEF), at push edge + 2.
  - sent_cnt = 1; idle returns to 1.
- Fairness: all 4 channels each push 3 words tagged {ch, seq}; the server always accepts.
  - Call order is ch0s0, ch1s0, ch2s0, ch3s0, ch0s1, ... ; sent_cnt = 12.
- Retry: RETRY_GAP=2, MAX_RETRY=0; the server rejects 3 times, then accepts word 0x55.
  - 4 calls, all carrying 0x55, with 2 call-free cycles between consecutive calls.
  - sent_cnt = 1; no drop.
- Drop: MAX_RETRY=3; the server always rejects channel 1's word 0xA5.
  - 3 calls, then drop_pulse for 1 cycle with drop_ch = 1.
  - The next word on channel 1 is granted afterwards; sent_cnt is unchanged.
- Backpressure: FIFO_DEPTH=4; the server rejects forever and channel 0 pushes 6 words.
  - in_rdy[0] falls after 4 accepted pushes; words 5 and 6 are held by the producer.
  - Other channels still fill their own FIFOs.
- Reset mid-flight: assert rst during SEND with 2 words queued on channel 3.
  - Outputs go to reset values immediately; no DPI call while rst is high.
  - After release, no queued word is ever sent.
